// File: rtl/cotm32_trap_ctrl_pkg.sv
// Shared privilege and Zicsr types for the cotm32 core, plus the trap
// controller's own FSM and event-kind enums.
package cotm32_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_mode_t;

    // Bit 31 marks interrupts; the low bits are the architectural code.
    typedef enum logic [31:0] {
        INSTR_MISALIGNED   = 32'd0,
        INSTR_ACCESS_FAULT = 32'd1,
        ILLEGAL_INST       = 32'd2,
        BREAKPOINT         = 32'd3,
        LOAD_MISALIGNED    = 32'd4,
        LOAD_ACCESS_FAULT  = 32'd5,
        STORE_MISALIGNED   = 32'd6,
        STORE_ACCESS_FAULT = 32'd7,
        ECALL_U            = 32'd8,
        ECALL_M            = 32'd11,
        IRQ_M_SOFT         = 32'h8000_0003,
        IRQ_M_TIMER        = 32'h8000_0007,
        IRQ_M_EXT          = 32'h8000_000B
    } trap_cause_t;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } zicsr_csr_op_t;

    typedef enum logic [11:0] {
        CSR_MSTATUS = 12'h300,
        CSR_MIE     = 12'h304,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342,
        CSR_MTVAL   = 12'h343,
        CSR_MIP     = 12'h344
    } zicsr_csr_addr_t;

    typedef struct packed {
        logic [18:0] rsvd31;
        priv_mode_t  mpp;
        logic [2:0]  rsvd10;
        logic        mpie;
        logic [2:0]  rsvd6;
        logic        mie;
        logic [2:0]  rsvd2;
    } zicsr_val_mstatus_t;

    typedef struct packed {
        logic [19:0] rsvd31;
        logic        meie;
        logic [2:0]  rsvd10;
        logic        mtie;
        logic [2:0]  rsvd6;
        logic        msie;
        logic [2:0]  rsvd2;
    } zicsr_val_mie_t;

    typedef struct packed {
        logic [19:0] rsvd31;
        logic        meip;
        logic [2:0]  rsvd10;
        logic        mtip;
        logic [2:0]  rsvd6;
        logic        msip;
        logic [2:0]  rsvd2;
    } zicsr_val_mip_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } zicsr_val_mtvec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2
    } trap_state_t;

    typedef enum logic [1:0] {
        EXC  = 2'd0,
        IRQ  = 2'd1,
        MRET = 2'd2
    } trap_kind_t;

    localparam zicsr_val_mstatus_t MSTATUS_RESET = '{
        rsvd31: '0, mpp: PRIV_M, rsvd10: '0, mpie: 1'b0,
        rsvd6: '0, mie: 1'b0, rsvd2: '0
    };

    function automatic logic [31:0] csrApply(input zicsr_csr_op_t op,
                                             input logic [31:0] oldVal,
                                             input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return oldVal | wdata;
            CSR_RC:  return oldVal & ~wdata;
            default: return oldVal;
        endcase
    endfunction

endpackage

// File: rtl/cotm32_trap_ctrl_if.sv
// Pipeline-facing bundle of the trap controller: event inputs, interrupt
// lines, Zicsr port and flush/redirect handshake.
interface cotm32_trap_ctrl_if
    import cotm32_trap_ctrl_pkg::*;
();
    logic          exc_valid_i;
    trap_cause_t   exc_cause_i;
    logic [31:0]   exc_pc_i;
    logic [31:0]   exc_tval_i;
    logic          mret_i;
    logic          boundary_i;
    logic [31:0]   boundary_pc_i;
    logic          irq_sw_i;
    logic          irq_timer_i;
    logic          irq_ext_i;
    zicsr_csr_op_t csr_op_i;
    logic [11:0]   csr_addr_i;
    logic [31:0]   csr_wdata_i;
    logic [31:0]   csr_rdata_o;
    logic          csr_illegal_o;
    logic          flush_o;
    logic          stall_o;
    logic          redirect_valid_o;
    logic [31:0]   redirect_pc_o;
    priv_mode_t    priv_o;

    modport master (
        output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
               boundary_i, boundary_pc_i, irq_sw_i, irq_timer_i, irq_ext_i,
               csr_op_i, csr_addr_i, csr_wdata_i,
        input  csr_rdata_o, csr_illegal_o, flush_o, stall_o,
               redirect_valid_o, redirect_pc_o, priv_o
    );

    modport slave (
        input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i,
               boundary_i, boundary_pc_i, irq_sw_i, irq_timer_i, irq_ext_i,
               csr_op_i, csr_addr_i, csr_wdata_i,
        output csr_rdata_o, csr_illegal_o, flush_o, stall_o,
               redirect_valid_o, redirect_pc_o, priv_o
    );
endinterface

// File: rtl/cotm32_trap_ctrl_sync.sv
// Single-bit N-flop synchronizer for asynchronous interrupt lines.
module cotm32_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    // Fewer than two flops gives no metastability protection, so clamp.
    localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];
endmodule

// File: rtl/cotm32_trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs and sequences trap entry
// and mret as a two-cycle flush/redirect handshake with the pipeline.
module cotm32_trap_ctrl
    import cotm32_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cotm32_trap_ctrl_if.slave bus
);

    trap_state_t        state_q, state_d;
    trap_kind_t         kind_q, kind_d;
    trap_cause_t        cause_q, cause_d;
    logic [31:0]        target_q, target_d;
    logic [31:0]        tval_q, tval_d;
    logic [31:0]        pc_q, pc_d;
    priv_mode_t         priv_q, priv_d;
    zicsr_val_mstatus_t mstatus_q, mstatus_d;
    zicsr_val_mie_t     mie_q, mie_d;
    zicsr_val_mtvec_t   mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;

    logic           swSync, timerSync, extSync;
    zicsr_val_mip_t mip;
    logic [31:0]    csrRdata, csrNew;
    logic           csrAddrValid, csrIllegal, csrWe;
    logic           extPend, swPend, timerPend, irqReq;
    trap_cause_t    irqCause;
    logic [31:0]    irqCauseBits;
    logic           flush, stall, redirValid;
    logic [31:0]    redirPc;

    cotm32_sync #(.STAGES(SYNC_STAGES)) uSyncSw (
        .clk(clk), .rst_n(rst_n), .d_i(bus.irq_sw_i), .q_o(swSync)
    );
    cotm32_sync #(.STAGES(SYNC_STAGES)) uSyncTimer (
        .clk(clk), .rst_n(rst_n), .d_i(bus.irq_timer_i), .q_o(timerSync)
    );
    cotm32_sync #(.STAGES(SYNC_STAGES)) uSyncExt (
        .clk(clk), .rst_n(rst_n), .d_i(bus.irq_ext_i), .q_o(extSync)
    );

    always_comb begin
        mip      = '0;
        mip.meip = extSync;
        mip.mtip = timerSync;
        mip.msip = swSync;
    end

    always_comb begin
        csrRdata     = '0;
        csrAddrValid = 1'b1;
        case (bus.csr_addr_i)
            CSR_MSTATUS: csrRdata = mstatus_q;
            CSR_MIE:     csrRdata = mie_q;
            CSR_MTVEC:   csrRdata = mtvec_q;
            CSR_MEPC:    csrRdata = mepc_q;
            CSR_MCAUSE:  csrRdata = mcause_q;
            CSR_MTVAL:   csrRdata = mtval_q;
            CSR_MIP:     csrRdata = mip;
            default:     csrAddrValid = 1'b0;
        endcase
    end

    assign csrIllegal = (bus.csr_op_i != CSR_NONE) &&
                        ((priv_q == PRIV_U) || !csrAddrValid);
    assign csrNew     = csrApply(bus.csr_op_i, csrRdata, bus.csr_wdata_i);
    assign csrWe      = (state_q == IDLE) && (bus.csr_op_i != CSR_NONE) && !csrIllegal;

    assign extPend   = mip.meip & mie_q.meie;
    assign swPend    = mip.msip & mie_q.msie;
    assign timerPend = mip.mtip & mie_q.mtie;
    assign irqReq    = bus.boundary_i && (extPend || swPend || timerPend) &&
                       ((priv_q == PRIV_U) || mstatus_q.mie);
    assign irqCause  = extPend ? IRQ_M_EXT : (swPend ? IRQ_M_SOFT : IRQ_M_TIMER);
    assign irqCauseBits = irqCause;

    // CSR writes land first so an event in the same cycle sees the new
    // mtvec/mepc when its target is latched.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cause_d    = cause_q;
        target_d   = target_q;
        tval_d     = tval_q;
        pc_d       = pc_q;
        priv_d     = priv_q;
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        flush      = 1'b0;
        stall      = 1'b0;
        redirValid = 1'b0;
        redirPc    = '0;

        case (state_q)
            IDLE: begin
                if (csrWe) begin
                    case (bus.csr_addr_i)
                        CSR_MSTATUS: begin
                            mstatus_d.mie  = csrNew[3];
                            mstatus_d.mpie = csrNew[7];
                            if ((csrNew[12:11] == PRIV_U) || (csrNew[12:11] == PRIV_M)) begin
                                mstatus_d.mpp = priv_mode_t'(csrNew[12:11]);
                            end
                        end
                        CSR_MIE: begin
                            mie_d      = '0;
                            mie_d.meie = csrNew[11];
                            mie_d.mtie = csrNew[7];
                            mie_d.msie = csrNew[3];
                        end
                        CSR_MTVEC:  mtvec_d  = zicsr_val_mtvec_t'(csrNew & 32'hFFFF_FFFD);
                        CSR_MEPC:   mepc_d   = csrNew & 32'hFFFF_FFFC;
                        CSR_MCAUSE: mcause_d = csrNew;
                        CSR_MTVAL:  mtval_d  = csrNew;
                        default: ;
                    endcase
                end

                if (bus.exc_valid_i) begin
                    state_d  = COMMIT;
                    kind_d   = EXC;
                    cause_d  = bus.exc_cause_i;
                    pc_d     = bus.exc_pc_i;
                    tval_d   = bus.exc_tval_i;
                    target_d = {mtvec_d.base, 2'b00};
                end else if (irqReq) begin
                    state_d  = COMMIT;
                    kind_d   = IRQ;
                    cause_d  = irqCause;
                    pc_d     = bus.boundary_pc_i;
                    tval_d   = '0;
                    target_d = {mtvec_d.base, 2'b00};
                    if (mtvec_d.mode == 2'b01) begin
                        target_d = {mtvec_d.base, 2'b00} + {25'd0, irqCauseBits[4:0], 2'b00};
                    end
                end else if (bus.mret_i) begin
                    state_d  = COMMIT;
                    kind_d   = MRET;
                    target_d = mepc_d;
                end
            end

            COMMIT: begin
                flush   = 1'b1;
                stall   = 1'b1;
                state_d = REDIRECT;
                if (kind_q == MRET) begin
                    mstatus_d.mie  = mstatus_q.mpie;
                    mstatus_d.mpie = 1'b1;
                    mstatus_d.mpp  = PRIV_U;
                    priv_d         = mstatus_q.mpp;
                end else begin
                    mepc_d         = pc_q & 32'hFFFF_FFFC;
                    mcause_d       = cause_q;
                    mtval_d        = tval_q;
                    mstatus_d.mpie = mstatus_q.mie;
                    mstatus_d.mie  = 1'b0;
                    mstatus_d.mpp  = priv_q;
                    priv_d         = PRIV_M;
                end
            end

            REDIRECT: begin
                stall      = 1'b1;
                redirValid = 1'b1;
                redirPc    = target_q;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kind_q    <= EXC;
            cause_q   <= INSTR_MISALIGNED;
            target_q  <= '0;
            tval_q    <= '0;
            pc_q      <= '0;
            priv_q    <= PRIV_M;
            mstatus_q <= MSTATUS_RESET;
            mie_q     <= '0;
            mtvec_q   <= '{base: RESET_MTVEC[31:2], mode: 2'b00};
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cause_q   <= cause_d;
            target_q  <= target_d;
            tval_q    <= tval_d;
            pc_q      <= pc_d;
            priv_q    <= priv_d;
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
        end
    end

    assign bus.csr_rdata_o      = csrRdata;
    assign bus.csr_illegal_o    = csrIllegal;
    assign bus.flush_o          = flush;
    assign bus.stall_o          = stall;
    assign bus.redirect_valid_o = redirValid;
    assign bus.redirect_pc_o    = redirPc;
    assign bus.priv_o           = priv_q;

endmodule

// File: doc/cotm32_trap_ctrl.md
# cotm32_trap_ctrl

Machine-mode trap controller for the cotm32 core. It owns the trap CSRs: mstatus, mie, mtvec, mepc, mcause, mtval and a read-only mip. It arbitrates synchronous exceptions, `mret` and the three machine interrupt lines. It sequences trap entry and return as a fixed two-cycle flush/redirect handshake with the pipeline. It sits beside the execute stage and serves the Zicsr read/write port.

## Interface
Parameters:
- `RESET_MTVEC`, default `32'h0000_0000`: reset value of mtvec; bits [1:0] are forced to 0.
- `SYNC_STAGES`, default `2`: flop depth of each interrupt-line synchronizer; minimum 2.

Ports:
- `clk`  in  1  core clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `exc_valid_i`  in  1  the retiring instruction raised an exception.
- `exc_cause_i`  in  `trap_cause_t`  exception cause; never an interrupt code.
- `exc_pc_i`  in  32  PC of the faulting instruction.
- `exc_tval_i`  in  32  faulting address or instruction bits.
- `mret_i`  in  1  an `mret` is retiring; it is only ever issued in M mode.
- `boundary_i`  in  1  core is at an interruptible instruction boundary.
- `boundary_pc_i`  in  32  PC of the next instruction to execute.
- `irq_sw_i`, `irq_timer_i`, `irq_ext_i`  in  1 each  asynchronous level interrupt lines.
- `csr_op_i`  in  `zicsr_csr_op_t`  CSR operation.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  32  rs1 or zero-extended immediate.
- `csr_rdata_o`  out  32  old CSR value; combinational.
- `csr_illegal_o`  out  1  access is illegal; combinational.
- `flush_o`  out  1  kill all in-flight instructions.
- `stall_o`  out  1  hold fetch and decode.
- `redirect_valid_o`  out  1  load `redirect_pc_o` into the PC.
- `redirect_pc_o`  out  32  trap vector or mepc.
- `priv_o`  out  `priv_mode_t`  current privilege mode.

## Operation
- Reset values:
  - FSM in IDLE; priv = `PRIV_M`.
  - mstatus = 0 except mpp = `PRIV_M`.
  - mie, mepc, mcause, mtval = 0; mtvec = `RESET_MTVEC`.
  - All outputs low; `redirect_pc_o` = 0.
- mip reflects the synchronized lines: meip = ext, mtip = timer, msip = sw. mip is not writable.
- Interrupt request condition, evaluated in IDLE:
  - `boundary_i` = 1, and
  - (mip & mie) is nonzero, and
  - (priv = `PRIV_U`) or mstatus.mie = 1.
  - Selection among pending interrupts: MEI > MSI > MTI.
- Event priority in IDLE: exception > interrupt > `mret`. Lower-priority events in the same cycle are dropped; upstream replays them.
- FSM states:
  - IDLE, on an event: latch the event kind, cause, target and tval, then go to COMMIT.
  - COMMIT: assert `flush_o` and `stall_o`. At the end of the cycle, perform the CSR update below, then go to REDIRECT.
  - REDIRECT: assert `redirect_valid_o`, `stall_o` and the target on `redirect_pc_o`, then go to IDLE.
- CSR update in COMMIT, trap case:
  - mepc = pc with bits [1:0] cleared. pc is `exc_pc_i` for exceptions, `boundary_pc_i` for interrupts.
  - mcause = cause.
  - mtval = `exc_tval_i` for exceptions, 0 for interrupts.
  - mpie = mie, mie = 0, mpp = priv, priv = M.
- CSR update in COMMIT, `mret` case: mie = mpie, mpie = 1, priv = mpp, mpp = U.
- Trap target:
  - mtvec.base for exceptions, or when mtvec.mode = 0.
  - mtvec.base + 4·code for interrupts when mode = 1, computed mod 2^32.
  - `mret` target is mepc.
- CSR port, accepted only in IDLE:
  - RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
  - The write takes effect at the next edge; rdata is always the old value.
  - `csr_illegal_o` = 1 if op ≠ NONE and priv = `PRIV_U`, or if the address is not in `zicsr_csr_addr_t`. An illegal access performs no write.
- WARL write rules:
  - mstatus: only mie, mpie, mpp are writable. mpp written with a value other than U or M keeps its old value.
  - mie: only meie, mtie, msie are writable.
  - mtvec: mode[1] is forced to 0.
  - mepc: bits [1:0] are forced to 0.
  - mip: writes are ignored and are not illegal.
- A CSR write in the same cycle as an event is still performed. The trap update is applied one cycle later, in COMMIT, and uses the newly written values.

## Timing
- Event sampled at edge N:
  - COMMIT runs during cycle N+1 (`flush_o`).
  - REDIRECT runs during cycle N+2.
  - The controller is back in IDLE at N+3.
- Inputs other than reset are ignored outside IDLE.
- Interrupt line to mip: `SYNC_STAGES` cycles. The interrupt is taken at the first IDLE boundary after that.
- `rst_n` asserted mid-sequence returns the controller to reset state asynchronously; no redirect is issued.

## Structure
- Add to the shared privilege package: a `trap_state_t` enum (IDLE/COMMIT/REDIRECT) and a `trap_kind_t` enum (EXC/IRQ/MRET).
- Existing package types are used unchanged: `trap_cause_t`, `zicsr_val_*_t`, `zicsr_csr_op_t`, `priv_mode_t`.
- Sub-module `cotm32_sync`: a parameterized N-flop single-bit synchronizer, instantiated three times.

## Test plan
- Reset with `RESET_MTVEC`=`32'h100`: priv = M, all outputs 0. Reading mtvec returns `32'h100`; reading mstatus returns `32'h1800`.
- `exc_valid_i` with cause=`ILLEGAL_INST`, pc=`32'h204`, tval=`32'hDEAD` at edge N:
  - `flush_o` high in N+1; redirect to `32'h100` in N+2.
  - mepc = `32'h204`, mcause = 2, mtval = `32'hDEAD`, mstatus.mie = 0.
- Set mie.meie and mstatus.mie, mtvec = `32'h101`, raise `irq_ext_i` with `boundary_i`=1:
  - redirect to `32'h12C` (base `32'h100` + 4·11).
  - mcause = `32'h8000000B`, mtval = 0.
- `irq_sw_i` and `irq_timer_i` both pending and enabled: MSI is taken (mcause = `32'h80000003`).
- Exception and `mret` in the same cycle: only the exception commits. Then `mret` alone restores mie from mpie, sets priv = mpp, and redirects to mepc.
- In U mode, `csr_op_i`=RW to mstatus: `csr_illegal_o`=1 and mstatus is unchanged. Writing mpp=`2'b01` in M mode keeps the old mpp.
